bus1_arbiter: RTL

- Shares the CPU-side cache bus (A1/D1/C1) between NREQ requesters (CPU cores or a DMA port) with round-robin arbitration.
- Sequences the two-beat command phase, hands bus ownership to the cache, captures the C1 response (one or two data beats) and returns it to the winning requester with a done pulse.
- Sits between the requesters and the bus-1 cache. Bus pins are split into out/in/oe for the top-level tristate wrapper.

---
 rtl/bus1_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/bus1_arbiter.sv
// Round-robin owner of cache bus 1: runs the command beats, hands the bus to the cache, returns the response. Optional macro BUS1_ARB_TIMEOUT_EN.
// Latency with an immediate response: req to done 5 cycles (RD8/RD16/writes), 6 (RD32), 4 (INV).
// One transaction in flight; other requesters hold req_i until their done_o, and the cache stalls us by withholding RESPONSE.
module bus1_arbiter #(
    parameter int NREQ  = 2,
    parameter int A_W   = 15,
    parameter int OFF_W = 4,
    parameter int D_W   = 16,
    parameter int C_W   = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ*C_W-1:0]           cmd_i,
    input  logic [NREQ*(A_W+OFF_W)-1:0]   addr_i,
    input  logic [NREQ*32-1:0]            wdata_i,
    output logic [NREQ-1:0]               done_o,
    output logic [31:0]                   rdata_o,
    output logic                          busy_o,
    output logic [A_W-1:0]                bus_a_o,
    output logic [D_W-1:0]                bus_d_o,
    input  logic [D_W-1:0]                bus_d_i,
    output logic [C_W-1:0]                bus_c_o,
    input  logic [C_W-1:0]                bus_c_i,
`ifdef BUS1_ARB_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    output logic                          bus_oe_o,
    output logic                          bus_doe_o
);

    localparam int AD_W = A_W + OFF_W;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [C_W-1:0] C_NOP  = C_W'(0);
    localparam logic [C_W-1:0] C_RD8  = C_W'(1);
    localparam logic [C_W-1:0] C_RD16 = C_W'(2);
    localparam logic [C_W-1:0] C_RD32 = C_W'(3);
    localparam logic [C_W-1:0] C_INV  = C_W'(4);
    localparam logic [C_W-1:0] C_WR8  = C_W'(5);
    localparam logic [C_W-1:0] C_WR16 = C_W'(6);
    localparam logic [C_W-1:0] C_WR32 = C_W'(7);
    localparam logic [C_W-1:0] C_RESP = C_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        CMD2,
        WAIT,
        BEAT2,
        RECLAIM
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_q, win_q, win, rr_next;
    logic [IW:0]        idx;
    logic               any_req;
    logic [C_W-1:0]     win_cmd;
    logic [C_W-1:0]     cmd_q;
    logic [AD_W-1:0]    addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               is_wr;
    logic               resp;
    logic               tmo;

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (!any_req && req_i[idx[IW-1:0]]) begin
                any_req = 1'b1;
                win     = idx[IW-1:0];
            end
        end
    end

    assign rr_next = (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
    assign win_cmd = cmd_i[win*C_W +: C_W];
    assign is_wr   = (cmd_q == C_WR8) || (cmd_q == C_WR16) || (cmd_q == C_WR32);
    assign resp    = (bus_c_i == C_RESP);

`ifdef BUS1_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_q;

    // 65535th consecutive WAIT cycle without a response.
    assign tmo       = (tmo_cnt_q == 16'hFFFE);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + 16'd1 : 16'd0;
            if (state_q == WAIT && !resp && tmo) timeout_q <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bus_oe_o  = 1'b1;
        bus_c_o   = C_NOP;
        bus_a_o   = '0;
        bus_d_o   = '0;
        bus_doe_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Undefined command completes through RECLAIM without touching the bus.
                if (any_req) state_d = (win_cmd == C_NOP) ? RECLAIM : CMD1;
            end
            CMD1: begin
                bus_a_o = addr_q[AD_W-1:OFF_W];
                bus_c_o = cmd_q;
                if (is_wr) begin
                    bus_d_o   = D_W'(wdata_q[15:0]);
                    bus_doe_o = 1'b1;
                end
                state_d = (cmd_q == C_INV) ? WAIT : CMD2;
            end
            CMD2: begin
                bus_a_o = A_W'(addr_q[OFF_W-1:0]);
                bus_c_o = cmd_q;
                if (is_wr) begin
                    bus_d_o   = D_W'((cmd_q == C_WR32) ? wdata_q[31:16] : wdata_q[15:0]);
                    bus_doe_o = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                bus_oe_o = 1'b0;
                if (resp)     state_d = (cmd_q == C_RD32) ? BEAT2 : RECLAIM;
                else if (tmo) state_d = RECLAIM;
            end
            BEAT2: begin
                bus_oe_o = 1'b0;
                state_d  = RECLAIM;
            end
            RECLAIM: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q    <= '0;
            win_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    win_q   <= win;
                    rr_q    <= rr_next;
                    cmd_q   <= win_cmd;
                    addr_q  <= addr_i[win*AD_W +: AD_W];
                    wdata_q <= wdata_i[win*32 +: 32];
                    rdata_q <= '0;
                end
                WAIT: begin
                    if (resp) begin
                        if (cmd_q == C_RD8)       rdata_q        <= {24'b0, bus_d_i[7:0]};
                        else if (cmd_q == C_RD16) rdata_q        <= 32'(bus_d_i);
                        else if (cmd_q == C_RD32) rdata_q[15:0]  <= bus_d_i[15:0];
                    end else if (tmo) begin
                        rdata_q <= 32'hDEAD_BEEF;
                    end
                end
                BEAT2:   rdata_q[31:16] <= bus_d_i[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        done_o = '0;
        for (int k = 0; k < NREQ; k++)
            done_o[k] = (state_q == RECLAIM) && (win_q == IW'(k));
    end

    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rdata_q;

endmodule
